// File: rtl/imem_loader.sv
// imem_loader: loads a byte stream into the fetch stage's instruction RAM.
// Bytes arrive over a valid/ready handshake and are packed big-endian into
// 32-bit words. The words are written sequentially from word 0. While a load
// is running, busy stalls the PC and the read port returns a nop (all zeros).
module imem_loader #(
    parameter int          DEPTH_LOG2 = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_3000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic                  load_end,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  busy,
    output logic                  load_done,
    output logic                  overflow,
    output logic [DEPTH_LOG2:0]   word_count,
    input  logic [31:0]           pc,
    output logic [31:0]           instr
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    // Write pointer value meaning "every word of the RAM has been written".
    localparam logic [DEPTH_LOG2:0] FULL_PTR = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PAD  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t                  state_r;
    logic [DEPTH_LOG2:0]     wr_ptr_r;
    logic [1:0]              byte_cnt_r;
    // Only the three most recent bytes are ever needed; the fourth byte is
    // taken straight from byte_data when the word completes.
    logic [23:0]             shift_r;
    logic                    overflow_r;
    logic                    byte_ready_r;
    logic                    busy_r;
    logic                    load_done_r;

    logic                    accept_s;
    logic                    word_go_s;
    logic                    full_s;
    logic                    wr_en_s;
    logic [31:0]             wr_word_s;
    logic [1:0]              cnt_next_s;
    logic [DEPTH_LOG2-1:0]   rd_idx_s;

    logic [31:0]             mem [0:DEPTH-1];

    assign full_s = (wr_ptr_r == FULL_PTR);

    // Decide whether a word is produced this cycle and assemble its contents.
    always_comb begin
        accept_s   = 1'b0;
        word_go_s  = 1'b0;
        wr_word_s  = 32'h0000_0000;
        cnt_next_s = byte_cnt_r;
        case (state_r)
            ST_LOAD: begin
                accept_s = byte_valid;
                if (byte_valid) begin
                    cnt_next_s = byte_cnt_r + 2'd1;
                    if (byte_cnt_r == 2'd3) begin
                        word_go_s = 1'b1;
                        wr_word_s = {shift_r, byte_data};
                    end else begin
                        word_go_s = 1'b0;
                    end
                end else begin
                    cnt_next_s = byte_cnt_r;
                end
            end
            ST_PAD: begin
                word_go_s = 1'b1;
                // Left-justify the pending bytes and zero-fill the rest.
                case (byte_cnt_r)
                    2'd1:    wr_word_s = {shift_r[7:0], 24'h00_0000};
                    2'd2:    wr_word_s = {shift_r[15:0], 16'h0000};
                    2'd3:    wr_word_s = {shift_r, 8'h00};
                    default: wr_word_s = 32'h0000_0000;
                endcase
            end
            default: begin
                accept_s  = 1'b0;
                word_go_s = 1'b0;
            end
        endcase
        wr_en_s = word_go_s & ~full_s;
    end

    // Load sequencer: state, write pointer, packing shift word and flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            wr_ptr_r     <= {(DEPTH_LOG2+1){1'b0}};
            byte_cnt_r   <= 2'd0;
            shift_r      <= 24'h00_0000;
            overflow_r   <= 1'b0;
            byte_ready_r <= 1'b0;
            busy_r       <= 1'b0;
            load_done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    load_done_r <= 1'b0;
                    if (load_start) begin
                        state_r      <= ST_LOAD;
                        wr_ptr_r     <= {(DEPTH_LOG2+1){1'b0}};
                        byte_cnt_r   <= 2'd0;
                        shift_r      <= 24'h00_0000;
                        overflow_r   <= 1'b0;
                        byte_ready_r <= 1'b1;
                        busy_r       <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (accept_s) begin
                        shift_r    <= {shift_r[15:0], byte_data};
                        byte_cnt_r <= cnt_next_s;
                    end
                    if (word_go_s) begin
                        if (full_s) begin
                            overflow_r <= 1'b1;
                        end else begin
                            wr_ptr_r <= wr_ptr_r + {{DEPTH_LOG2{1'b0}}, 1'b1};
                        end
                    end
                    // A byte arriving with load_end is counted before deciding.
                    if (load_end) begin
                        byte_ready_r <= 1'b0;
                        if (cnt_next_s != 2'd0) begin
                            state_r <= ST_PAD;
                            busy_r  <= 1'b1;
                        end else begin
                            state_r     <= ST_DONE;
                            busy_r      <= 1'b0;
                            load_done_r <= 1'b1;
                        end
                    end
                end
                ST_PAD: begin
                    if (full_s) begin
                        overflow_r <= 1'b1;
                    end else begin
                        wr_ptr_r <= wr_ptr_r + {{DEPTH_LOG2{1'b0}}, 1'b1};
                    end
                    byte_cnt_r   <= 2'd0;
                    state_r      <= ST_DONE;
                    byte_ready_r <= 1'b0;
                    busy_r       <= 1'b0;
                    load_done_r  <= 1'b1;
                end
                ST_DONE: begin
                    state_r      <= ST_IDLE;
                    byte_ready_r <= 1'b0;
                    busy_r       <= 1'b0;
                    load_done_r  <= 1'b0;
                end
                default: begin
                    state_r      <= ST_IDLE;
                    byte_ready_r <= 1'b0;
                    busy_r       <= 1'b0;
                    load_done_r  <= 1'b0;
                end
            endcase
        end
    end

    // Instruction RAM write port; contents survive reset by design.
    always_ff @(posedge clk) begin
        if (wr_en_s && !reset) begin
            mem[wr_ptr_r[DEPTH_LOG2-1:0]] <= wr_word_s;
        end
    end

    // PC-relative word index; arithmetic wraps, so any PC lands in the RAM.
    assign rd_idx_s = DEPTH_LOG2'((pc - BASE_ADDR) >> 2'd2);

    assign instr      = busy_r ? 32'h0000_0000 : mem[rd_idx_s];
    assign byte_ready = byte_ready_r;
    assign busy       = busy_r;
    assign load_done  = load_done_r;
    assign overflow   = overflow_r;
    assign word_count = wr_ptr_r;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two instances (4096-word and 4-word RAMs) share the
// same stimulus; a byte-list reference model predicts RAM contents, counts
// and flags from the packing rules.
module tb_imem_loader;

    localparam logic [31:0] BASE = 32'h0000_3000;
    localparam int BIG_D = 4096;
    localparam int SML_D = 4;

    logic        clk;
    logic        reset, load_start, load_end, byte_valid;
    logic [7:0]  byte_data;
    logic [31:0] pc;

    logic        rdy_b, busy_b, done_b, ovf_b;
    logic [12:0] wc_b;
    logic [31:0] instr_b;
    logic        rdy_s, busy_s, done_s, ovf_s;
    logic [2:0]  wc_s;
    logic [31:0] instr_s;

    imem_loader #(.DEPTH_LOG2(12), .BASE_ADDR(BASE)) dut_b (
        .clk(clk), .reset(reset), .load_start(load_start), .load_end(load_end),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(rdy_b),
        .busy(busy_b), .load_done(done_b), .overflow(ovf_b), .word_count(wc_b),
        .pc(pc), .instr(instr_b));

    imem_loader #(.DEPTH_LOG2(2), .BASE_ADDR(BASE)) dut_s (
        .clk(clk), .reset(reset), .load_start(load_start), .load_end(load_end),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(rdy_s),
        .busy(busy_s), .load_done(done_s), .overflow(ovf_s), .word_count(wc_s),
        .pc(pc), .instr(instr_s));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mem_b [0:BIG_D-1];
    bit          val_b [0:BIG_D-1];
    logic [31:0] mem_s [0:SML_D-1];
    bit          val_s [0:SML_D-1];
    logic [7:0]  stim_q[$];
    logic [7:0]  acc_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Word w of the accepted stream, big-endian, zero-filled past the end.
    function automatic logic [31:0] pack_word(input int w);
        logic [31:0] r;
        r = 32'h0;
        for (int k = 0; k < 4; k++) begin
            r = r << 8;
            if (w * 4 + k < acc_q.size()) r[7:0] = acc_q[w * 4 + k];
        end
        return r;
    endfunction

    task automatic commit_word(input int w);
        if (w < BIG_D) begin mem_b[w] = pack_word(w); val_b[w] = 1'b1; end
        if (w < SML_D) begin mem_s[w] = pack_word(w); val_s[w] = 1'b1; end
    endtask

    task automatic check_status(input string tag, input int words);
        check({tag, "_wc_big"},    32'(wc_b),  32'(imin(words, BIG_D)));
        check({tag, "_wc_small"},  32'(wc_s),  32'(imin(words, SML_D)));
        check({tag, "_ovf_big"},   32'(ovf_b), 32'(words > BIG_D));
        check({tag, "_ovf_small"}, 32'(ovf_s), 32'(words > SML_D));
    endtask

    task automatic check_flags(input string tag, input logic bz, input logic rd, input logic dn);
        check({tag, "_busy_big"},   32'(busy_b), 32'(bz));
        check({tag, "_busy_small"}, 32'(busy_s), 32'(bz));
        check({tag, "_rdy_big"},    32'(rdy_b),  32'(rd));
        check({tag, "_rdy_small"},  32'(rdy_s),  32'(rd));
        check({tag, "_done_big"},   32'(done_b), 32'(dn));
        check({tag, "_done_small"}, 32'(done_s), 32'(dn));
    endtask

    // Read every known word back through PCs with random high and low bits.
    task automatic check_reads();
        logic [31:0] off;
        for (int w = 0; w < 8; w++) begin
            if (val_b[w]) begin
                off = ($urandom() << 14) | 32'(w << 2) | 32'($urandom_range(0, 3));
                pc = BASE + off;
                #1;
                check("rd_big", instr_b, mem_b[w]);
            end
        end
        for (int w = 0; w < SML_D; w++) begin
            if (val_s[w]) begin
                off = ($urandom() << 4) | 32'(w << 2) | 32'($urandom_range(0, 3));
                pc = BASE + off;
                #1;
                check("rd_small", instr_s, mem_s[w]);
            end
        end
    endtask

    // gap_mode: 0 always valid, 1 valid toggles 1/0, 2 random valid.
    // end_sep: load_end in its own cycle instead of with the last byte.
    // abort_n >= 0: reset after that many accepted bytes.
    task automatic do_load(input int gap_mode, input bit end_sep, input int abort_n);
        int i, cycles, n;
        bit v, par;
        acc_q.delete();
        // load_end outside LOAD must not start anything.
        load_end = 1'b1; byte_valid = 1'b1; byte_data = 8'($urandom);
        tick();
        check("idle_end_busy", 32'(busy_b | busy_s), 32'd0);
        load_end = 1'b0; byte_valid = 1'b0; load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check_flags("start", 1'b1, 1'b1, 1'b0);
        check_status("start", 0);
        i = 0; cycles = 0; par = 1'b1;
        while (i < stim_q.size() && cycles < 500) begin
            if (abort_n >= 0 && i == abort_n) break;
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = par;
                default: v = 1'($urandom_range(0, 1));
            endcase
            par = ~par;
            byte_valid = v;
            byte_data  = v ? stim_q[i] : 8'($urandom);
            load_end   = (!end_sep && abort_n < 0 && v && i == stim_q.size() - 1);
            load_start = 1'($urandom_range(0, 1));
            pc = $urandom();
            #1;
            check("busy_instr_big", instr_b, 32'h0);
            check("busy_instr_small", instr_s, 32'h0);
            tick();
            cycles++;
            if (v) begin
                acc_q.push_back(stim_q[i]);
                i++;
                if (acc_q.size() % 4 == 0) commit_word(acc_q.size() / 4 - 1);
            end
            check_status("stream", acc_q.size() / 4);
        end
        load_start = 1'b0; byte_valid = 1'b0; load_end = 1'b0;
        if (abort_n >= 0) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
            check_flags("abort", 1'b0, 1'b0, 1'b0);
            check_status("abort", 0);
            return;
        end
        check("stream_budget", 32'(i), 32'(stim_q.size()));
        if (end_sep) begin
            load_end = 1'b1;
            tick();
            load_end = 1'b0;
            check_status("end", acc_q.size() / 4);
        end
        n = acc_q.size();
        if (n % 4 != 0) begin
            check_flags("pad", 1'b1, 1'b0, 1'b0);
            pc = $urandom();
            #1;
            check("pad_instr_big", instr_b, 32'h0);
            check("pad_instr_small", instr_s, 32'h0);
            tick();
            commit_word(n / 4);
        end
        check_flags("done", 1'b0, 1'b0, 1'b1);
        check_status("done", (n + 3) / 4);
        tick();
        check_flags("idle", 1'b0, 1'b0, 1'b0);
        check_status("idle", (n + 3) / 4);
        check_reads();
    endtask

    initial begin
        reset = 1'b1; load_start = 1'b0; load_end = 1'b0;
        byte_valid = 1'b0; byte_data = 8'h00; pc = BASE;
        for (int w = 0; w < BIG_D; w++) val_b[w] = 1'b0;
        for (int w = 0; w < SML_D; w++) val_s[w] = 1'b0;
        tick();
        tick();
        check_flags("reset", 1'b0, 1'b0, 1'b0);
        check_status("reset", 0);
        reset = 1'b0;
        tick();
        check_flags("post_reset", 1'b0, 1'b0, 1'b0);

        // Word 0 = 3C01ABCD, then read it at the base PC.
        stim_q = '{8'h3C, 8'h01, 8'hAB, 8'hCD};
        do_load(0, 1'b0, -1);
        pc = BASE;
        #1;
        check("preload_w0", instr_b, 32'h3C01_ABCD);

        // Two full words, load_end with the last byte.
        stim_q = '{8'h24, 8'h01, 8'h00, 8'h05, 8'h34, 8'h22, 8'h00, 8'h10};
        do_load(0, 1'b0, -1);
        pc = 32'h0000_3004;
        #1;
        check("two_w1", instr_b, 32'h3422_0010);
        pc = 32'h0000_3000;
        #1;
        check("two_w0", instr_s, 32'h2401_0005);

        // Partial word, load_end in a separate cycle.
        stim_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB};
        do_load(0, 1'b1, -1);
        pc = 32'h0000_3004;
        #1;
        check("partial_w1", instr_b, 32'hAABB_0000);

        // Same 8 bytes with valid toggling every cycle.
        stim_q = '{8'h24, 8'h01, 8'h00, 8'h05, 8'h34, 8'h22, 8'h00, 8'h10};
        do_load(1, 1'b0, -1);
        pc = 32'h0000_3004;
        #1;
        check("gap_w1", instr_b, 32'h3422_0010);

        // 20 bytes: the 4-word instance overflows on the 5th word.
        stim_q.delete();
        for (int k = 0; k < 20; k++) stim_q.push_back(8'($urandom));
        do_load(0, 1'b0, -1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("ovf_sticky", 32'(ovf_s), 32'd1);
        end

        // Reset after 6 bytes of a fresh load.
        stim_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h55, 8'h66, 8'h77, 8'h88};
        do_load(0, 1'b0, 6);
        check_reads();
        pc = 32'h0000_3000;
        #1;
        check("abort_w0", instr_b, 32'hDEAD_BEEF);

        // Randomized loads.
        for (int r = 0; r < 8; r++) begin
            stim_q.delete();
            for (int k = 0; k < int'($urandom_range(1, 24)); k++) stim_q.push_back(8'($urandom));
            do_load(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Write-side companion to the fetch stage's instruction memory. Accepts a byte stream over a valid/ready handshake and packs it big-endian into 32-bit words. Writes the words sequentially into its own instruction RAM, which the fetch stage reads by PC. While a load is in progress, `busy` stalls the PC and `instr` returns a nop, so the pipeline never fetches a half-written program.

## Interface

Parameters:
- `DEPTH_LOG2`, default 12: RAM holds 2^DEPTH_LOG2 words.
- `BASE_ADDR`, default 32'h0000_3000: PC value that maps to word 0.

Ports:
- `clk` input 1: the single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high.
- `load_start` input 1: begin a load; honoured only in IDLE.
- `load_end` input 1: end of stream; honoured only in LOAD.
- `byte_valid` input 1: `byte_data` is valid.
- `byte_data` input 8: next program byte, most-significant byte of each word first.
- `byte_ready` output 1: loader accepts a byte this cycle.
- `busy` output 1: load in progress; the fetch stage holds its PC while this is 1.
- `load_done` output 1: one-cycle pulse when a load completes.
- `overflow` output 1: sticky flag; bytes arrived after the RAM was full.
- `word_count` output DEPTH_LOG2+1: number of words written in the current or last load.
- `pc` input 32: fetch address.
- `instr` output 32: instruction at `pc`.

## Operation

- State machine: IDLE, LOAD, PAD, DONE.
- IDLE:
  - `byte_ready`=0, `busy`=0.
  - `load_start`=1 moves to LOAD and clears `wr_ptr`, `byte_cnt` (2 bits), the shift word, and `overflow`.
- LOAD:
  - `byte_ready`=1, `busy`=1.
  - A byte is accepted when `byte_valid`&`byte_ready`. Each accepted byte updates `shift = {shift[23:0], byte_data}` and `byte_cnt++`.
  - On the 4th byte (`byte_cnt`==3), `{shift[23:0], byte_data}` is written to `mem[wr_ptr]` on the same edge, and `wr_ptr++`.
  - If `wr_ptr`==2^DEPTH_LOG2 at that edge, the word is dropped, `overflow` is set, and `wr_ptr` is held.
  - If `load_end` and an accepted byte occur in the same cycle, the byte is processed first.
  - `load_end` with a resulting `byte_cnt`!=0 goes to PAD; otherwise it goes to DONE.
- PAD:
  - Exactly one cycle.
  - Writes the partial word left-justified and zero-filled: shift << 8·(4−n), where n is the number of pending bytes.
  - `wr_ptr++`, with the same full/overflow rule as LOAD; clears `byte_cnt`; goes to DONE.
  - `byte_ready`=0, `busy`=1.
- DONE:
  - `load_done`=1, `busy`=0, `byte_ready`=0.
  - Goes to IDLE the next cycle.
- Ignored inputs: `load_start` outside IDLE and `load_end` outside LOAD have no effect.
- `word_count` = `wr_ptr`, range 0..2^DEPTH_LOG2.
- Read port, combinational:
  - `idx = (pc − BASE_ADDR)[DEPTH_LOG2+1:2]`.
  - `instr = busy ? 32'h0000_0000 : mem[idx]`.
  - Address arithmetic is modulo 2^32; out-of-range PCs wrap into the RAM, with no fault.
  - `pc[1:0]` is ignored.
- RAM contents:
  - Not affected by reset.
  - May be preloaded at elaboration via `$readmemh("code.txt")`.
  - A load overwrites only words 0..`wr_ptr`−1; higher words are retained.

## Timing

- Reset values: state IDLE, `byte_ready`=0, `busy`=0, `load_done`=0, `overflow`=0, `word_count`=0. Reset takes priority over every other input.
- Reset mid-load returns to IDLE next edge. Words already written stay in the RAM, and any partial word is discarded.
- `load_start` at edge N: `busy`=1 and `byte_ready`=1 during cycle N+1.
- Throughput: one byte per cycle; a word is written every 4 accepted bytes. `byte_valid` may drop at any time without losing state.
- A word written at edge N is visible on `instr` from cycle N+1, once `busy` is low.
- Latency from the `load_end` edge to the `load_done` cycle:
  - 1 cycle if there is no partial word.
  - 2 cycles if there is a partial word (PAD).
- `busy` is 1 exactly in LOAD and PAD.

## Test plan

- Reset and idle:
  - Stimulus: hold `reset` 2 cycles, then `pc`=0x3000 with a preloaded word 0 = 0x3C01ABCD.
  - Required: all outputs at their reset values, and `instr`=0x3C01ABCD.
- Two full words:
  - Stimulus: `load_start`, then 8 back-to-back bytes 24 01 00 05 34 22 00 10, `load_end` asserted with the last byte.
  - Required: `mem[0]`=0x24010005, `mem[1]`=0x34220010, `word_count`=2, `load_done` pulse one cycle after the last byte, `instr` at `pc`=0x3004 returns 0x34220010.
- Partial word:
  - Stimulus: bytes 11 22 33 44 AA BB, then `load_end`.
  - Required: PAD cycle seen, `mem[1]`=0xAABB0000, `word_count`=2, `load_done` 2 cycles after `load_end`.
- Backpressure and gaps:
  - Stimulus: same 8 bytes as the two-full-words scenario with `byte_valid` toggled 1/0 every cycle.
  - Required: identical RAM result, and `instr`=0 for every cycle `busy`=1.
- Overflow:
  - Stimulus: `DEPTH_LOG2`=2, 20 bytes streamed.
  - Required: words 0..3 written, 5th word dropped, `overflow`=1 sticky until the next `load_start`, `word_count`=4.
- Reset mid-load:
  - Stimulus: after 6 bytes, assert `reset`.
  - Required: next cycle IDLE, `busy`=0, `word_count`=0, `mem[0]` keeps the first word, the partial 2 bytes are never written.
